// File: rtl/psum_shift_collector_if.sv
// Stream handshake bundle for the partial-sum collector: serial capture input
// and serial drain output, each with a valid/ready pair.
interface psum_shift_collector_if #(
  parameter int DATA_W = 16
);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_last
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_last
  );

endinterface

// File: rtl/psum_shift_collector.sv
// Collects p serial partial sums into a shift chain, exposes the chain in
// parallel, then drains the captured words serially in capture order.
module psum_shift_collector #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 24,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [CNT_W-1:0]        p,
  input  logic                    abort,
  psum_shift_collector_if.slave   bus,
  output logic [DEPTH*DATA_W-1:0] q_flat,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DRAIN   = 2'd2
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  p_reg_q;
  logic [CNT_W-1:0]  cap_cnt_q;
  logic [CNT_W-1:0]  drn_cnt_q;
  logic [DATA_W-1:0] chain_q [DEPTH];

  logic              in_ready_q;
  logic              out_valid_q;
  logic              out_last_q;
  logic [DATA_W-1:0] out_data_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic [CNT_W-1:0]  cap_idx_s;
  logic [CNT_W-1:0]  drn_idx_s;
  logic [DATA_W-1:0] cap_sel_s;
  logic [DATA_W-1:0] out_data_cap_d;
  logic [DATA_W-1:0] out_data_drn_d;
  logic              p_legal_s;
  logic              in_beat_s;
  logic              out_beat_s;
  logic              cap_final_s;

  // Handshake qualifiers and the chain taps feeding the registered out_data.
  // Word 0 lands at stage p_reg-1 after the closing shift, which is old stage
  // p_reg-2 (or in_data itself when p_reg is 1); later words step down by one.
  always_comb begin
    p_legal_s   = (p >= CNT_W'(1)) && (p <= CNT_W'(DEPTH));
    in_beat_s   = bus.in_valid && in_ready_q;
    out_beat_s  = out_valid_q && bus.out_ready;
    cap_final_s = (cap_cnt_q + CNT_W'(1)) == p_reg_q;
    cap_idx_s   = p_reg_q - CNT_W'(2);
    drn_idx_s   = p_reg_q - drn_cnt_q - CNT_W'(2);
    cap_sel_s      = {DATA_W{1'b0}};
    out_data_drn_d = {DATA_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      cap_sel_s      = (cap_idx_s == CNT_W'(i)) ? chain_q[i] : cap_sel_s;
      out_data_drn_d = (drn_idx_s == CNT_W'(i)) ? chain_q[i] : out_data_drn_d;
    end
    out_data_cap_d = (p_reg_q == CNT_W'(1)) ? bus.in_data : cap_sel_s;
  end

  // Collector FSM: state, counters, chain and every registered output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      p_reg_q     <= {CNT_W{1'b0}};
      cap_cnt_q   <= {CNT_W{1'b0}};
      drn_cnt_q   <= {CNT_W{1'b0}};
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= {DATA_W{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        chain_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (abort) begin
        // Chain contents are deliberately kept so a partial capture stays visible.
        state_q     <= S_IDLE;
        cap_cnt_q   <= {CNT_W{1'b0}};
        drn_cnt_q   <= {CNT_W{1'b0}};
        in_ready_q  <= 1'b0;
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
        busy_q      <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              if (p_legal_s) begin
                p_reg_q    <= p;
                cap_cnt_q  <= {CNT_W{1'b0}};
                drn_cnt_q  <= {CNT_W{1'b0}};
                state_q    <= S_CAPTURE;
                in_ready_q <= 1'b1;
                busy_q     <= 1'b1;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          S_CAPTURE: begin
            if (in_beat_s) begin
              chain_q[0] <= bus.in_data;
              for (int i = 1; i < DEPTH; i++) begin
                chain_q[i] <= chain_q[i-1];
              end
              cap_cnt_q <= cap_cnt_q + CNT_W'(1);
              if (cap_final_s) begin
                state_q     <= S_DRAIN;
                in_ready_q  <= 1'b0;
                out_valid_q <= 1'b1;
                out_data_q  <= out_data_cap_d;
                out_last_q  <= (p_reg_q == CNT_W'(1));
              end
            end
          end
          S_DRAIN: begin
            if (out_beat_s) begin
              drn_cnt_q <= drn_cnt_q + CNT_W'(1);
              if (out_last_q) begin
                state_q     <= S_IDLE;
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
                busy_q      <= 1'b0;
                done_q      <= 1'b1;
              end else begin
                out_data_q <= out_data_drn_d;
                out_last_q <= ((drn_cnt_q + CNT_W'(2)) == p_reg_q);
              end
            end
          end
          default: begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign q_flat[g*DATA_W +: DATA_W] = chain_q[g];
  end

endmodule

// File: doc/psum_shift_collector.md
PSUM_SHIFT_COLLECTOR -- requirements
Module: psum_shift_collector

Interface
REQ-001 SHALL have parameter DATA_W, default 16, width of each partial-sum word.
REQ-002 SHALL have parameter DEPTH, default 24, maximum number of filters per PE (chain length).
REQ-003 SHALL have parameter CNT_W, default $clog2(DEPTH+1), width of p and internal counters.
REQ-004 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-005 SHALL have port rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-006 SHALL have port start  input  1  single-cycle request to begin a collection; sampled in IDLE only.
REQ-007 SHALL have port p  input  CNT_W  number of words to collect; sampled with start.
REQ-008 SHALL have port abort  input  1  synchronous abandon of the current collection.
REQ-009 SHALL have port in_valid  input  1  in_data holds a valid word.
REQ-010 SHALL have port in_data  input  DATA_W  serial partial-sum input.
REQ-011 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-012 SHALL have port out_valid  output  1  out_data holds a valid word.
REQ-013 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-014 SHALL have port out_data  output  DATA_W  serial drain output, in capture order.
REQ-015 SHALL have port out_last  output  1  high with the final drained word.
REQ-016 SHALL have port q_flat  output  DEPTH*DATA_W  parallel chain contents; stage i at bits [i*DATA_W +: DATA_W].
REQ-017 SHALL have port busy  output  1  high in CAPTURE or DRAIN.
REQ-018 SHALL have port done  output  1  one-cycle pulse after the last drain beat.
REQ-019 SHALL have port err  output  1  one-cycle pulse on start with illegal p.

Function
REQ-020 SHALL implement states IDLE, CAPTURE, DRAIN; busy = (state != IDLE).
REQ-021 SHALL, in IDLE with start=1 and 1 <= p <= DEPTH, latch p into p_reg, clear cap_cnt and drn_cnt, and enter CAPTURE next cycle.
REQ-022 SHALL, in IDLE with start=1 and p=0 or p>DEPTH, pulse err for one cycle and remain IDLE.
REQ-023 SHALL ignore start outside IDLE.
REQ-024 SHALL drive in_ready=1 only in CAPTURE.
REQ-025 SHALL, on each in_valid&&in_ready beat, shift the chain: stage0 <= in_data, stage i <= stage i-1 for i=1..DEPTH-1, and increment cap_cnt.
REQ-026 SHALL hold the chain unchanged on every cycle without an accepted beat.
REQ-027 SHALL enter DRAIN on the cycle after the beat that makes cap_cnt equal p_reg; the k-th captured word (k=0 first) then sits in stage p_reg-1-k.
REQ-028 SHALL, in DRAIN, drive out_valid=1 and out_data = stage(p_reg-1-drn_cnt); the chain does not shift during DRAIN.
REQ-029 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-030 SHALL drive out_last=1 when drn_cnt = p_reg-1 in DRAIN.
REQ-031 SHALL, on each out_valid&&out_ready beat, increment drn_cnt; on the out_last beat, return to IDLE and pulse done the following cycle.
REQ-032 SHALL keep q_flat valid and unchanged in IDLE after a collection until the next accepted input beat.
REQ-033 SHALL, on abort=1 in any state, go to IDLE next cycle, clear counters, not pulse done, and retain chain contents; abort takes priority over start, input and output beats in the same cycle.
REQ-034 SHALL drive out_valid=0, out_last=0 and in_ready=0 in IDLE.
REQ-035 SHALL support back-to-back: start may be accepted in the cycle done is high.

Reset
REQ-036 SHALL, while rst_n=0, force state IDLE, all chain stages, counters, p_reg to 0, and all outputs (in_ready, out_valid, out_data, out_last, busy, done, err, q_flat) to 0.
REQ-037 SHALL, on reset mid-CAPTURE or mid-DRAIN, discard the collection with no done pulse.
REQ-038 SHALL leave IDLE on the first start after rst_n deasserts.

Verification
REQ-039 SHALL verify: p=3, inputs 0x11,0x22,0x33 back-to-back, out_ready=1 -> q_flat stages 2,1,0 = 0x11,0x22,0x33; out_data 0x11,0x22,0x33, out_last on 0x33, done one cycle later.
REQ-040 SHALL verify: p=24, 24 inputs with in_valid toggling every other cycle -> all 24 words captured, stage0 = last word, drain in order.
REQ-041 SHALL verify: p=2 drain with out_ready low 3 cycles on first word -> out_data held 3 cycles, no word lost or duplicated.
REQ-042 SHALL verify: start with p=0 and p=25 -> err pulses once each, busy stays 0, in_ready stays 0.
REQ-043 SHALL verify: abort after 2 of 4 inputs -> IDLE next cycle, no done, q_flat stage0/stage1 retain last two words; rst_n low mid-DRAIN -> all outputs 0 immediately.
